// File: rtl/stream_mem_responder_if.sv
`timescale 1ns/1ps
// Request/response bus between the stream-to-memory adapter (master) and a memory target (slave).
// mem_resp_err exists only when STREAM_MEM_RESPONDER_ERR_EN is defined.
interface stream_mem_responder_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int NumBytes = DataWidth / 8;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_we;
  logic [AddrWidth-1:0] mem_req_addr;
  logic [DataWidth-1:0] mem_req_wdata;
  logic [NumBytes-1:0]  mem_req_be;
  logic                 mem_resp_valid;
  logic [DataWidth-1:0] mem_resp_rdata;
`ifdef STREAM_MEM_RESPONDER_ERR_EN
  logic                 mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
`else
  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
`endif
endinterface

// File: rtl/stream_mem_responder.sv
`timescale 1ns/1ps
// Word-addressed SRAM target with byte enables and a fixed Latency-deep response pipeline.
// Define STREAM_MEM_RESPONDER_ERR_EN to reject requests with address bits above the storage range.
module stream_mem_responder #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int NumWords  = 256,
  parameter int Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  stream_mem_responder_if.slave mem_if
);

  localparam int NumBytes = DataWidth / 8;
  localparam int OffW     = $clog2(NumBytes);
  localparam int IdxW     = $clog2(NumWords);
  localparam int UsedW    = OffW + IdxW;

  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "stream_mem_responder: Latency must be >= 1");
  end
  if ((DataWidth < 8) || ((DataWidth % 8) != 0)) begin : g_bad_width
    $fatal(1, "stream_mem_responder: DataWidth must be a nonzero multiple of 8");
  end
  if ((NumWords < 2) || ((NumWords & (NumWords - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "stream_mem_responder: NumWords must be a power of two >= 2");
  end
  if (AddrWidth < UsedW) begin : g_bad_addr
    $fatal(1, "stream_mem_responder: AddrWidth too small for NumWords");
  end

  logic                 req_hs;
  logic                 addr_err;
  logic                 wr_en;
  logic [IdxW-1:0]      word_idx;
  logic [DataWidth-1:0] rd_word;
  logic                 unused_addr_bits;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [Latency-1:0]   pipe_valid_q;
  logic [DataWidth-1:0] pipe_data_q [Latency];

  // Ready is independent of valid so the adapter can use it to decide whether to present.
  assign mem_if.mem_req_ready = !stall_i && !rst_i;
  assign req_hs               = mem_if.mem_req_valid && mem_if.mem_req_ready;
  assign word_idx             = mem_if.mem_req_addr[OffW +: IdxW];
  assign unused_addr_bits     = ^mem_if.mem_req_addr;

`ifdef STREAM_MEM_RESPONDER_ERR_EN
  if (AddrWidth > UsedW) begin : g_addr_hi
    assign addr_err = |mem_if.mem_req_addr[AddrWidth-1:UsedW];
  end else begin : g_addr_full
    assign addr_err = 1'b0;
  end
`else
  assign addr_err = 1'b0;
`endif

  assign wr_en   = req_hs && mem_if.mem_req_we && !addr_err;
  assign rd_word = (req_hs && !mem_if.mem_req_we && !addr_err) ? mem_q[word_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NumWords; w++) begin
        mem_q[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (mem_if.mem_req_be[b]) begin
          mem_q[word_idx][b*8 +: 8] <= mem_if.mem_req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Stage data is zero whenever its valid is zero, so idle output data stays 0 without gating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      for (int s = 0; s < Latency; s++) begin
        pipe_data_q[s] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= req_hs;
      pipe_data_q[0]  <= rd_word;
      for (int s = 1; s < Latency; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_data_q[s]  <= pipe_data_q[s-1];
      end
    end
  end

  assign mem_if.mem_resp_valid = pipe_valid_q[Latency-1];
  assign mem_if.mem_resp_rdata = pipe_data_q[Latency-1];

`ifdef STREAM_MEM_RESPONDER_ERR_EN
  logic [Latency-1:0] pipe_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_err_q <= '0;
    end else begin
      pipe_err_q[0] <= req_hs && addr_err;
      for (int s = 1; s < Latency; s++) begin
        pipe_err_q[s] <= pipe_err_q[s-1];
      end
    end
  end

  assign mem_if.mem_resp_err = pipe_err_q[Latency-1];
`endif

endmodule
